// File: rtl/stdio_pkg.sv
// Shared definitions for the stdout print path.
// Holds the ASCII control characters, the characters-per-word count, the
// nibble-to-ASCII helper and the FSM state types for the word sequencer and the
// UART byte transmitter.
package stdio_pkg;

    localparam logic [7:0]  ASCII_CR       = 8'h0D;
    localparam logic [7:0]  ASCII_LF       = 8'h0A;
    localparam int unsigned CHARS_PER_WORD = 6;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    typedef enum logic {
        WordIdle,
        WordSend
    } word_state_e;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};  // 8'h37 + 10 = 'A'
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   val_i   byte valid
//   data_i  byte to send, LSB first
//   rdy_o   byte accepted on a clock edge where val_i && rdy_o
//   tx_o    serial line, idle high
// rdy_o also rises in the last cycle of a stop bit, so a byte offered then
// starts with no idle gap between characters.
module uart_tx_byte
    import stdio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       val_i,
    input  logic [7:0] data_i,
    output logic       rdy_o,
    output logic       tx_o
);

    localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            baud_wrap;

    assign baud_wrap = (cnt_q == BaudMax);
    assign tx_o      = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = baud_wrap ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rdy_o   = 1'b0;

        unique case (state_q)
            TxIdle: begin
                cnt_d = '0;
                rdy_o = !rst_i;
            end
            TxStart: begin
                if (baud_wrap) begin
                    state_d = TxData;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            TxData: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = TxStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            TxStop: begin
                if (baud_wrap) begin
                    state_d = TxIdle;
                    rdy_o   = !rst_i;
                end
            end
            default: state_d = TxIdle;
        endcase

        if (val_i && rdy_o) begin
            state_d = TxStart;
            shift_d = data_i;
            tx_d    = 1'b0;
            cnt_d   = '0;
            bit_d   = 3'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// Prints each 16-bit stdout word as four uppercase hex digits plus CR LF on
// an 8N1 UART line.
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   stdout_val_i   word valid from the core
//   stdout_data_i  word to print
//   stdout_rdy_o   ready to accept a word (only while idle and out of reset)
//   uart_tx_o      serial line, idle high
//   busy_o         registered, high while a word is being sent
module stdout_uart_tx
    import stdio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stdout_val_i,
    input  logic [15:0] stdout_data_i,
    output logic        stdout_rdy_o,
    output logic        uart_tx_o,
    output logic        busy_o
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("stdout_uart_tx: CLKS_PER_BIT must be 2 or more");
    end

    localparam logic [2:0] LastChar = 3'(CHARS_PER_WORD - 1);

    word_state_e state_q, state_d;
    logic [2:0]  char_q, char_d;
    logic [15:0] hold_q, hold_d;
    logic        busy_q;
    logic        byte_val;
    logic        byte_rdy;
    logic [7:0]  byte_data;

    function automatic logic [7:0] char_at(input logic [15:0] w, input logic [2:0] idx);
        unique case (idx)
            3'd0:    return hex_to_ascii(w[15:12]);
            3'd1:    return hex_to_ascii(w[11:8]);
            3'd2:    return hex_to_ascii(w[7:4]);
            3'd3:    return hex_to_ascii(w[3:0]);
            3'd4:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        char_d       = char_q;
        hold_d       = hold_q;
        byte_val     = 1'b0;
        byte_data    = char_at(hold_q, char_q + 3'd1);
        stdout_rdy_o = (state_q == WordIdle) && !rst_i;

        unique case (state_q)
            WordIdle: begin
                // Char 0 comes straight from the input so the start bit
                // leaves on the acceptance edge itself.
                if (stdout_val_i && stdout_rdy_o) begin
                    byte_val  = 1'b1;
                    byte_data = hex_to_ascii(stdout_data_i[15:12]);
                    hold_d    = stdout_data_i;
                    char_d    = 3'd0;
                    state_d   = WordSend;
                end
            end
            WordSend: begin
                if (byte_rdy) begin
                    if (char_q == LastChar) begin
                        state_d = WordIdle;
                    end else begin
                        byte_val = 1'b1;
                        char_d   = char_q + 3'd1;
                    end
                end
            end
            default: state_d = WordIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WordIdle;
            char_q  <= 3'd0;
            hold_q  <= 16'h0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            hold_q  <= hold_d;
            busy_q  <= (state_d != WordIdle);
        end
    end

    assign busy_o = busy_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .val_i (byte_val),
        .data_i(byte_data),
        .rdy_o (byte_rdy),
        .tx_o  (uart_tx_o)
    );

endmodule

// File: tb/tb_stdout_uart_tx.sv
module tb_stdout_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        val4, val7;
    logic [15:0] data4, data7;
    logic        rdy4, tx4, busy4;
    logic        rdy7, tx7, busy7;

    always #5 clk = ~clk;

    stdout_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .stdout_val_i (val4),
        .stdout_data_i(data4),
        .stdout_rdy_o (rdy4),
        .uart_tx_o    (tx4),
        .busy_o       (busy4)
    );

    stdout_uart_tx #(.CLKS_PER_BIT(7)) dut7 (
        .clk_i        (clk),
        .rst_i        (rst),
        .stdout_val_i (val7),
        .stdout_data_i(data7),
        .stdout_rdy_o (rdy7),
        .uart_tx_o    (tx7),
        .busy_o       (busy7)
    );

    typedef struct {
        logic [15:0] word;
        logic [47:0] exp;
    } vec_t;

    vec_t tab [8];
    int total = 0;
    int bad = 0;
    int frame_bad = 0;
    int overlap = 0;
    int lowcnt;
    int held_bad;
    int misalign;
    int stop_bad;
    int t;
    logic prev;
    logic [7:0] dec_c;
    logic [7:0] rxq[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART decoder for the CLKS_PER_BIT=4 instance, sampling mid-bit.
    always begin
        @(negedge clk);
        if (tx4 === 1'b0) begin
            repeat (2) @(negedge clk);
            if (tx4 !== 1'b0) frame_bad++;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                dec_c[i] = tx4;
            end
            repeat (4) @(negedge clk);
            if (tx4 !== 1'b1) frame_bad++;
            rxq.push_back(dec_c);
        end
    end

    always @(negedge clk) begin
        if (busy4 === 1'b1 && rdy4 === 1'b1) overlap++;
    end

    task automatic check_word(input int idx);
        check($sformatf("char_count_%04h", tab[idx].word), rxq.size(), 6);
        if (rxq.size() == 6) begin
            for (int j = 0; j < 6; j++) begin
                check($sformatf("w%04h_c%0d", tab[idx].word, j), 32'(rxq[j]),
                      32'(tab[idx].exp[8*(5-j) +: 8]));
            end
        end
        rxq.delete();
    endtask

    // Called at a negedge; returns at the negedge where rdy4 is high again.
    task automatic send4(input logic [15:0] w, input bit keep, output int low);
        int waited = 0;
        val4  = 1'b1;
        data4 = w;
        while (rdy4 !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 32'(rdy4 === 1'b1), 1);
        @(negedge clk);
        check($sformatf("start_latency_%04h", w), 32'(tx4), 0);
        if (!keep) val4 = 1'b0;
        low = 0;
        while (rdy4 !== 1'b1 && low < 1000) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{16'h1A2F, 48'h3141_3246_0D0A};
        tab[1] = '{16'h0000, 48'h3030_3030_0D0A};
        tab[2] = '{16'hFFFF, 48'h4646_4646_0D0A};
        tab[3] = '{16'hBEEF, 48'h4245_4546_0D0A};
        tab[4] = '{16'h5678, 48'h3536_3738_0D0A};
        tab[5] = '{16'h9C3E, 48'h3943_3345_0D0A};
        tab[6] = '{16'hC0DE, 48'h4330_4445_0D0A};
        tab[7] = '{16'h1234, 48'h3132_3334_0D0A};

        rst   = 1'b1;
        val4  = 1'b0;
        data4 = 16'h0000;
        val7  = 1'b0;
        data7 = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx4), 1);
        check("reset_busy", 32'(busy4), 0);
        check("reset_rdy", 32'(rdy4), 0);
        check("reset_tx7", 32'(tx7), 1);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", 32'(rdy4), 1);

        // Independent words from the table.
        for (int i = 0; i < 8; i++) begin
            send4(tab[i].word, 1'b0, lowcnt);
            check($sformatf("rdy_low_%04h", tab[i].word), lowcnt, 240);
            check($sformatf("busy_done_%04h", tab[i].word), 32'(busy4), 0);
            check_word(i);
        end

        // Back-to-back with val held: one idle-high cycle between words.
        send4(16'h0000, 1'b1, lowcnt);
        check("b2b_rdy_low_0", lowcnt, 240);
        check("b2b_gap_idle", 32'(tx4), 1);
        check_word(1);
        send4(16'hFFFF, 1'b0, lowcnt);
        check("b2b_rdy_low_1", lowcnt, 240);
        check_word(2);

        // Producer waves val while busy, then drops it; nothing extra is sent.
        val4  = 1'b1;
        data4 = 16'hC0DE;
        @(negedge clk);
        data4 = 16'hDEAD;
        repeat (10) @(negedge clk);
        val4 = 1'b0;
        t = 0;
        while (rdy4 !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drop_val_idle", 32'(rdy4), 1);
        repeat (20) @(negedge clk);
        check_word(6);
        send4(16'hBEEF, 1'b0, lowcnt);
        check_word(3);
        repeat (300) @(negedge clk);
        check("no_extra_words", rxq.size(), 0);

        // Reset during data bit 3 of char 1 of 0x1234.
        val4  = 1'b1;
        data4 = 16'h1234;
        @(negedge clk);
        val4 = 1'b0;
        repeat (56) @(negedge clk);
        check("mid_bit3_low", 32'(tx4), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx4), 1);
        check("midrst_rdy", 32'(rdy4), 0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_tx", 32'(tx4), 1);
        check("postrst_rdy", 32'(rdy4), 1);
        repeat (60) @(negedge clk);
        check("postrst_line_idle", 32'(tx4), 1);
        rxq.delete();
        send4(16'h5678, 1'b0, lowcnt);
        check("postrst_rdy_low", lowcnt, 240);
        check_word(4);

        // Reset held with val high: nothing accepted.
        rst      = 1'b1;
        val4     = 1'b1;
        data4    = 16'hEEEE;
        held_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy4 !== 1'b0 || tx4 !== 1'b1 || busy4 !== 1'b0) held_bad++;
        end
        check("held_reset", held_bad, 0);
        val4 = 1'b0;
        rst  = 1'b0;
        repeat (100) @(negedge clk);
        check("held_reset_nothing_sent", rxq.size(), 0);
        check("held_reset_busy", 32'(busy4), 0);

        // Bit timing with CLKS_PER_BIT=7.
        val7  = 1'b1;
        data7 = 16'h0000;
        @(negedge clk);
        val7 = 1'b0;
        check("cpb7_start", 32'(tx7), 0);
        prev     = 1'b0;
        misalign = 0;
        stop_bad = 0;
        for (int off = 1; off < 420; off++) begin
            @(negedge clk);
            if (tx7 !== prev && (off % 7) != 0) misalign++;
            if (off >= 63 && off <= 69 && tx7 !== 1'b1) stop_bad++;
            if (off == 62) check("cpb7_bit7_low", 32'(tx7), 0);
            if (off == 70) check("cpb7_next_start", 32'(tx7), 0);
            if (off == 419) check("cpb7_rdy_low_end", 32'(rdy7), 0);
            prev = tx7;
        end
        check("cpb7_misaligned_edges", misalign, 0);
        check("cpb7_stop_bit", stop_bad, 0);
        @(negedge clk);
        check("cpb7_rdy_at_420", 32'(rdy7), 1);

        check("frame_errors", frame_bad, 0);
        check("rdy_while_busy", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
